// File: rtl/led_blink_coder.sv
// Blinks a 4-bit code on led_req as N ON/OFF pulses followed by a GAP, repeating while pending.
// Optional activity stretch in IDLE is built when LED_ACTIVITY_STRETCH_EN is defined.
module led_blink_coder #(
    parameter int TICK_DIV      = 1048576,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 4,
    parameter int GAP_TICKS     = 16,
    parameter int STRETCH_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [3:0] code,
    input  logic       activity,
    output logic       led_req,
    output logic       busy,
    output logic [3:0] code_active
);
    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

    localparam logic [23:0] DIV_LAST = 24'(TICK_DIV - 1);
    localparam logic [7:0]  ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST = 8'(OFF_TICKS - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_TICKS - 1);

    state_e      state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [7:0]  tick_q, tick_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [3:0]  code_active_q, code_active_d;
    logic        led_q, led_d;
    logic        tick_last, phase_done, stretch_on;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            tick_q        <= '0;
            pending_q     <= '0;
            remaining_q   <= '0;
            code_active_q <= '0;
            led_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            pending_q     <= pending_d;
            remaining_q   <= remaining_d;
            code_active_q <= code_active_d;
            led_q         <= led_d;
        end
    end

    // A strobe in the same cycle as an IDLE check or GAP exit wins over the stored code.
    always_comb begin
        pending_d     = code_valid ? code : pending_q;
        state_d       = state_q;
        remaining_d   = remaining_q;
        code_active_d = code_active_q;
        tick_last     = (presc_q == DIV_LAST);
        phase_done    = 1'b0;
        case (state_q)
            S_ON:    phase_done = tick_last && (tick_q == ON_LAST);
            S_OFF:   phase_done = tick_last && (tick_q == OFF_LAST);
            S_GAP:   phase_done = tick_last && (tick_q == GAP_LAST);
            default: phase_done = 1'b0;
        endcase
        case (state_q)
            S_IDLE: begin
                if (pending_d != 4'd0) begin
                    state_d       = S_ON;
                    remaining_d   = pending_d;
                    code_active_d = pending_d;
                end
            end
            S_ON: begin
                if (phase_done) begin
                    state_d     = S_OFF;
                    remaining_d = remaining_q - 4'd1;
                end
            end
            S_OFF: begin
                if (phase_done) begin
                    state_d = (remaining_q != 4'd0) ? S_ON : S_GAP;
                end
            end
            S_GAP: begin
                if (phase_done) begin
                    if (pending_d != 4'd0) begin
                        state_d       = S_ON;
                        remaining_d   = pending_d;
                        code_active_d = pending_d;
                    end else begin
                        state_d       = S_IDLE;
                        code_active_d = 4'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q || state_q == S_IDLE) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (tick_last) begin
            presc_d = '0;
            tick_d  = tick_q + 8'd1;
        end else begin
            presc_d = presc_q + 24'd1;
            tick_d  = tick_q;
        end
    end

    always_comb begin
        led_d = (state_d == S_ON) || ((state_d == S_IDLE) && stretch_on);
    end

`ifdef LED_ACTIVITY_STRETCH_EN
    localparam logic [31:0] STRETCH_LOAD = 32'(longint'(STRETCH_TICKS) * longint'(TICK_DIV));

    logic [31:0] stretch_q, stretch_d;
    logic        act_prev_q, act_prev_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stretch_q  <= '0;
            act_prev_q <= 1'b0;
        end else begin
            stretch_q  <= stretch_d;
            act_prev_q <= act_prev_d;
        end
    end

    always_comb begin
        act_prev_d = activity;
        stretch_d  = stretch_q;
        if (state_d == S_ON) begin
            stretch_d = '0;
        end else if (state_q == S_IDLE && activity && !act_prev_q) begin
            stretch_d = STRETCH_LOAD;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - 32'd1;
        end
    end

    assign stretch_on = (stretch_d != '0);
`else
    localparam int unused_stretch_ticks = STRETCH_TICKS;
    logic unused_activity;
    assign unused_activity = activity;
    assign stretch_on      = 1'b0;
`endif

    assign led_req     = led_q;
    assign busy        = (state_q != S_IDLE);
    assign code_active = code_active_q;
endmodule

// File: tb/tb_led_blink_coder.sv
// Self-checking bench for led_blink_coder: directed scenarios plus randomized run
// against a phase/duration reference model.
`timescale 1ns/1ps
module tb_led_blink_coder;
    localparam int TICK_DIV      = 4;
    localparam int ON_TICKS      = 2;
    localparam int OFF_TICKS     = 2;
    localparam int GAP_TICKS     = 3;
    localparam int STRETCH_TICKS = 2;

    localparam int P_IDLE = 0;
    localparam int P_ON   = 1;
    localparam int P_OFF  = 2;
    localparam int P_GAP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [3:0] code = 4'd0;
    logic       activity = 1'b0;
    logic       led_req;
    logic       busy;
    logic [3:0] code_active;

    led_blink_coder #(
        .TICK_DIV(TICK_DIV), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS),
        .GAP_TICKS(GAP_TICKS), .STRETCH_TICKS(STRETCH_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
        .activity(activity), .led_req(led_req), .busy(busy), .code_active(code_active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current phase, cycles left in it, blinks still to come after this one.
    int         m_phase = P_IDLE;
    int         m_left = 0;
    int         m_blinks = 0;
    int         m_stretch = 0;
    logic [3:0] m_pending = 4'd0;
    logic [3:0] m_active = 4'd0;
    logic       m_act_prev = 1'b0;

    logic       led_log  [0:127];
    logic       busy_log [0:127];
    logic [3:0] act_log  [0:127];
    int         log_n = 0;

    task automatic model_start();
        m_phase  = P_ON;
        m_left   = ON_TICKS * TICK_DIV;
        m_active = m_pending;
        m_blinks = int'(m_pending) - 1;
    endtask

    task automatic model_step(input logic cv, input logic [3:0] c, input logic act, input logic rn);
        int old_phase;
        if (!rn) begin
            m_phase = P_IDLE; m_left = 0; m_blinks = 0; m_stretch = 0;
            m_pending = 4'd0; m_active = 4'd0; m_act_prev = 1'b0;
            return;
        end
        old_phase = m_phase;
        if (cv) m_pending = c;
        if (m_phase == P_IDLE) begin
            if (m_pending != 4'd0) model_start();
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_phase == P_ON) begin
                    m_phase = P_OFF; m_left = OFF_TICKS * TICK_DIV;
                end else if (m_phase == P_OFF) begin
                    if (m_blinks > 0) begin
                        m_blinks--; m_phase = P_ON; m_left = ON_TICKS * TICK_DIV;
                    end else begin
                        m_phase = P_GAP; m_left = GAP_TICKS * TICK_DIV;
                    end
                end else if (m_pending != 4'd0) begin
                    model_start();
                end else begin
                    m_phase = P_IDLE; m_active = 4'd0;
                end
            end
        end
`ifdef LED_ACTIVITY_STRETCH_EN
        if (m_phase == P_ON && old_phase != P_ON) m_stretch = 0;
        else if (old_phase == P_IDLE && act && !m_act_prev) m_stretch = STRETCH_TICKS * TICK_DIV;
        else if (m_stretch > 0) m_stretch--;
`endif
        m_act_prev = act;
    endtask

    function automatic logic m_led();
        return (m_phase == P_ON) || (m_phase == P_IDLE && m_stretch > 0);
    endfunction

    task automatic drive_cycle(input logic cv, input logic [3:0] c, input logic act, input logic rn);
        code_valid = cv; code = c; activity = act; rst_n = rn;
        @(posedge clk);
        model_step(cv, c, act, rn);
        #1;
        if (log_n < 128) begin
            led_log[log_n]  = led_req;
            busy_log[log_n] = busy;
            act_log[log_n]  = code_active;
        end
        log_n++;
    endtask

    task automatic reset_dut();
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
        log_n = 0;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 4'd5, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd5, 1'b0, 1'b0);
        n_cmp++; if (led_req !== 1'b0) begin n_bad++; $display("FAIL reset_led got %b exp 0", led_req); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (code_active !== 4'd0) begin n_bad++; $display("FAIL reset_code_active got %0d exp 0", code_active); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
            n_cmp++; if (busy !== 1'b0 || led_req !== 1'b0) begin
                n_bad++; $display("FAIL reset_strobe_ignored cyc %0d got busy=%b led=%b exp 0/0", i, busy, led_req);
            end
        end
    endtask

    task automatic test_code3();
        logic exp_led;
        reset_dut();
        drive_cycle(1'b1, 4'd3, 1'b0, 1'b1);
        repeat (63) drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            exp_led = (i < 48) ? ((i % 16) < 8) : (i >= 60);
            n_cmp++; if (led_log[i] !== exp_led) begin
                n_bad++; $display("FAIL code3_led cyc %0d got %b exp %b", i, led_log[i], exp_led);
            end
            n_cmp++; if (busy_log[i] !== 1'b1 || act_log[i] !== 4'd3) begin
                n_bad++; $display("FAIL code3_busy_active cyc %0d got %b/%0d exp 1/3", i, busy_log[i], act_log[i]);
            end
        end
    endtask

    task automatic test_clear_code();
        logic exp_led, exp_busy;
        reset_dut();
        drive_cycle(1'b1, 4'd3, 1'b0, 1'b1);
        for (int i = 1; i < 80; i++) begin
            if (i == 18) drive_cycle(1'b1, 4'd0, 1'b0, 1'b1);
            else         drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 80; i++) begin
            exp_led  = (i < 48) && ((i % 16) < 8);
            exp_busy = (i < 60);
            n_cmp++; if (led_log[i] !== exp_led || busy_log[i] !== exp_busy) begin
                n_bad++; $display("FAIL clear_code cyc %0d got led=%b busy=%b exp %b/%b", i, led_log[i], busy_log[i], exp_led, exp_busy);
            end
        end
        n_cmp++; if (act_log[79] !== 4'd0) begin n_bad++; $display("FAIL clear_code_active got %0d exp 0", act_log[79]); end
    endtask

    task automatic test_code_change();
        logic exp_led; logic [3:0] exp_act;
        reset_dut();
        drive_cycle(1'b1, 4'd2, 1'b0, 1'b1);
        for (int i = 1; i < 124; i++) begin
            if (i == 3) drive_cycle(1'b1, 4'd5, 1'b0, 1'b1);
            else        drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 124; i++) begin
            if (i < 32)      exp_led = (i % 16) < 8;
            else if (i < 44) exp_led = 1'b0;
            else             exp_led = ((i - 44) % 16) < 8;
            exp_act = (i < 44) ? 4'd2 : 4'd5;
            n_cmp++; if (led_log[i] !== exp_led || act_log[i] !== exp_act || busy_log[i] !== 1'b1) begin
                n_bad++; $display("FAIL code_change cyc %0d got led=%b act=%0d busy=%b exp %b/%0d/1",
                                  i, led_log[i], act_log[i], busy_log[i], exp_led, exp_act);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        drive_cycle(1'b1, 4'd4, 1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        drive_cycle(1'b0, 4'd0, 1'b0, 1'b0);
        n_cmp++; if (led_req !== 1'b0 || busy !== 1'b0 || code_active !== 4'd0) begin
            n_bad++; $display("FAIL reset_mid got led=%b busy=%b act=%0d exp 0/0/0", led_req, busy, code_active);
        end
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
            n_cmp++; if (led_req !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL reset_mid_idle cyc %0d got led=%b busy=%b exp 0/0", i, led_req, busy);
            end
        end
    endtask

    task automatic test_activity();
        logic exp_led;
        for (int pass = 0; pass < 2; pass++) begin
            reset_dut();
            for (int i = 0; i < 24; i++)
                drive_cycle(1'b0, 4'd0, (i == 0) || (pass == 1 && i == 5), 1'b1);
            for (int i = 0; i < 24; i++) begin
`ifdef LED_ACTIVITY_STRETCH_EN
                exp_led = (pass == 0) ? (i < 8) : (i < 13);
`else
                exp_led = 1'b0;
`endif
                n_cmp++; if (led_log[i] !== exp_led || busy_log[i] !== 1'b0) begin
                    n_bad++; $display("FAIL activity p%0d cyc %0d got led=%b busy=%b exp %b/0", pass, i, led_log[i], busy_log[i], exp_led);
                end
            end
        end
    endtask

    task automatic test_code_with_activity();
        logic exp_led;
        reset_dut();
        drive_cycle(1'b1, 4'd1, 1'b1, 1'b1);
        repeat (28) drive_cycle(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 29; i++) begin
            exp_led = (i < 8) || (i == 28);
            n_cmp++; if (led_log[i] !== exp_led || busy_log[i] !== 1'b1 || act_log[i] !== 4'd1) begin
                n_bad++; $display("FAIL code_with_activity cyc %0d got led=%b busy=%b act=%0d exp %b/1/1",
                                  i, led_log[i], busy_log[i], act_log[i], exp_led);
            end
        end
    endtask

    task automatic test_random();
        logic act_r = 1'b0;
        logic cv_r, rn_r;
        logic [3:0] c_r;
        reset_dut();
        for (int i = 0; i < 5000; i++) begin
            cv_r = ($urandom_range(0, 59) == 0);
            c_r  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) act_r = ~act_r;
            rn_r = ($urandom_range(0, 699) != 0);
            drive_cycle(cv_r, c_r, act_r, rn_r);
            n_cmp++; if (led_req !== m_led()) begin
                n_bad++; $display("FAIL random_led cyc %0d got %b exp %b", i, led_req, m_led());
            end
            n_cmp++; if (busy !== (m_phase != P_IDLE)) begin
                n_bad++; $display("FAIL random_busy cyc %0d got %b exp %b", i, busy, m_phase != P_IDLE);
            end
            n_cmp++; if (code_active !== m_active) begin
                n_bad++; $display("FAIL random_code_active cyc %0d got %0d exp %0d", i, code_active, m_active);
            end
        end
    endtask

    initial begin
        test_reset();
        test_code3();
        test_clear_code();
        test_code_change();
        test_reset_mid();
        test_activity();
        test_code_with_activity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/led_blink_coder.md
LED_BLINK_CODER -- requirements
Module: led_blink_coder

Interface
REQ-001 Parameter TICK_DIV, default 1048576: clk cycles per blink tick; legal range 1 to 2^24.
REQ-002 Parameter ON_TICKS, default 4: ticks the LED request is high per blink; legal range 1 to 255.
REQ-003 Parameter OFF_TICKS, default 4: ticks low between blinks; legal range 1 to 255.
REQ-004 Parameter GAP_TICKS, default 16: extra low ticks after the last blink of a sequence; legal range 1 to 255.
REQ-005 Parameter STRETCH_TICKS, default 2: activity stretch length in ticks; legal range 1 to 255.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 code_valid  in  1  single-cycle strobe; loads code.
REQ-009 code  in  4  blink count 0..15; 0 means "no code".
REQ-010 activity  in  1  event pulse, any width.
REQ-011 led_req  out  1  registered LED request; drives the LED flasher's override input.
REQ-012 busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 code_active  out  4  code of the sequence currently being blinked; 0 in IDLE.

Function
REQ-014 The block SHALL have a prescaler that is cleared on every FSM state change and that generates a tick every TICK_DIV cycles, so each state lasts exactly N*TICK_DIV cycles.
REQ-015 The FSM states SHALL be IDLE, ON, OFF and GAP.
REQ-016 The pending register SHALL capture code on any cycle with code_valid=1; a later strobe overwrites an earlier one (last write wins).
REQ-017 In IDLE, code_valid=1 with code!=0 at edge k: the FSM SHALL enter ON, code_active=code and blinks remaining=code, with led_req=1 from edge k+1 (1-cycle latency).
REQ-018 In IDLE with pending!=0 and no strobe, the FSM SHALL start the sequence from pending on the next edge.
REQ-019 ON SHALL end after ON_TICKS ticks and go to OFF, decrementing blinks remaining.
REQ-020 OFF SHALL end after OFF_TICKS ticks and go to ON if blinks remaining!=0, else to GAP.
REQ-021 GAP SHALL end after GAP_TICKS ticks; the FSM then reloads from pending: ON if pending!=0, else IDLE.
REQ-022 Code changes during a sequence SHALL NOT alter it; the new code takes effect at the GAP exit only.
REQ-023 code_valid with code=0 SHALL clear pending; the running sequence completes, then the FSM goes IDLE.
REQ-024 A simultaneous code_valid and GAP exit SHALL use the incoming code.
REQ-025 led_req SHALL be 1 exactly in ON, or in IDLE while the stretch counter is nonzero (REQ-031).
REQ-026 busy SHALL be 1 in ON, OFF and GAP.
REQ-027 Tick and state counters SHALL be sized for parameter maxima and SHALL never wrap within a state.

Reset
REQ-028 When rst_n=0 at an edge, the block SHALL set state=IDLE, pending=0, code_active=0, led_req=0, busy=0, and clear the prescaler and stretch counter.
REQ-029 Reset asserted mid-sequence SHALL force led_req=0 at the next edge, with no resumption afterwards.
REQ-030 code_valid sampled during reset SHALL be ignored.

Configuration
REQ-031 With macro LED_ACTIVITY_STRETCH_EN defined, a rising edge on activity in IDLE SHALL load the stretch counter to STRETCH_TICKS*TICK_DIV.
  - Another rising edge SHALL restart the counter.
  - Activity outside IDLE SHALL be ignored.
  - Entering ON SHALL clear the stretch counter.
REQ-032 Without LED_ACTIVITY_STRETCH_EN, activity SHALL be unused, the stretch logic absent, and led_req driven by the FSM only; ports are unchanged.

Verification (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=3, STRETCH_TICKS=2)
REQ-033 code_valid with code=3 in IDLE -> led_req 8 high, 8 low, repeated 3 times, then 12 further low cycles, then the pattern repeats; busy=1 throughout.
REQ-034 code_valid with code=0 during the 2nd blink of code 3 -> the 3rd blink and GAP complete, then IDLE; busy=0; no further pulses.
REQ-035 code=5 strobed during ON of code 2 -> sequence of 2 blinks, GAP, then 5 blinks; code_active changes 2->5 at the GAP exit.
REQ-036 rst_n=0 for 1 cycle during ON -> led_req=0 and busy=0 the next cycle; stays IDLE with no strobe.
REQ-037 With the macro defined, activity pulse in IDLE -> led_req high 8 cycles; a second pulse after 5 cycles extends high to 13 cycles total; without the macro -> led_req stays 0.
REQ-038 code_valid with code=1 in the same cycle as an activity pulse in IDLE -> single blink (8 high), stretch discarded, then GAP.
